lockout_controller: RTL

Downstream policy stage for the integrated unlocking system. It consumes that system's `unlock` and `pwd_incorrect` result flags and turns each new result into one attempt outcome. It then drives three things: a timed door-open strobe, a failed-attempt counter, and a timed lockout. During the lockout it withholds `entry_en`, which gates the upstream `p_valid`.

---
 rtl/lockout_controller.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/lockout_controller.sv
// Lockout policy stage: turns unlock / pwd_incorrect result flags into attempt
// outcomes, drives a timed door-open strobe, a consecutive-failure counter and
// a timed lockout that withholds entry_en from the upstream unlocking system.
module lockout_controller #(
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned OPEN_CYCLES    = 8,
    parameter int unsigned LOCKOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             unlock,
    input  logic                             pwd_incorrect,
    input  logic                             admin_clear,
    output logic                             entry_en,
    output logic                             door_open,
    output logic                             locked_out,
    output logic                             alarm,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count
);

    localparam int unsigned CntW     = $clog2(MAX_FAILS + 1);
    localparam int unsigned TimerMax = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES
                                                                       : LOCKOUT_CYCLES;
    // A single-cycle maximum would give a zero-width timer; keep one bit.
    localparam int unsigned TimerW   = (TimerMax > 1) ? $clog2(TimerMax) : 1;

    localparam logic [CntW-1:0]   CntLast  = CntW'(MAX_FAILS - 1);
    localparam logic [CntW-1:0]   CntMax   = CntW'(MAX_FAILS);
    localparam logic [TimerW-1:0] OpenLoad = TimerW'(OPEN_CYCLES - 1);
    localparam logic [TimerW-1:0] LockLoad = TimerW'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StArmed,
        StOpen,
        StLockout
    } state_e;

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [CntW-1:0]   fail_count_q, fail_count_d;
    logic              unlock_prev_q, pwd_prev_q;
    logic              entry_en_q, entry_en_d;
    logic              door_open_q, door_open_d;
    logic              locked_out_q, locked_out_d;
    logic              alarm_q, alarm_d;
    logic              success_ev, failure_ev;

    // Rising-edge detection; history resets high so a level held through reset is ignored.
    always_comb begin
        success_ev = unlock & ~unlock_prev_q;
        failure_ev = pwd_incorrect & ~pwd_prev_q;
    end

    // Next-state, timer, failure count and registered output decode.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        fail_count_d = fail_count_q;
        alarm_d      = 1'b0;

        if (admin_clear) begin
            state_d      = StArmed;
            timer_d      = '0;
            fail_count_d = '0;
        end else begin
            unique case (state_q)
                StArmed: begin
                    // Failure wins when both flags rise together.
                    if (failure_ev) begin
                        if (fail_count_q >= CntLast) begin
                            state_d      = StLockout;
                            fail_count_d = CntMax;
                            timer_d      = LockLoad;
                            alarm_d      = 1'b1;
                        end else begin
                            fail_count_d = fail_count_q + CntW'(1);
                        end
                    end else if (success_ev) begin
                        state_d      = StOpen;
                        fail_count_d = '0;
                        timer_d      = OpenLoad;
                    end
                end
                StOpen: begin
                    if (timer_q == '0) begin
                        state_d = StArmed;
                    end else begin
                        timer_d = timer_q - TimerW'(1);
                    end
                end
                StLockout: begin
                    if (timer_q == '0) begin
                        state_d      = StArmed;
                        fail_count_d = '0;
                    end else begin
                        timer_d = timer_q - TimerW'(1);
                    end
                end
                default: begin
                    state_d      = StArmed;
                    timer_d      = '0;
                    fail_count_d = '0;
                end
            endcase
        end

        entry_en_d   = (state_d == StArmed);
        door_open_d  = (state_d == StOpen);
        locked_out_d = (state_d == StLockout);
    end

    // All state, edge history and outputs are registered together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StArmed;
            timer_q       <= '0;
            fail_count_q  <= '0;
            unlock_prev_q <= 1'b1;
            pwd_prev_q    <= 1'b1;
            entry_en_q    <= 1'b1;
            door_open_q   <= 1'b0;
            locked_out_q  <= 1'b0;
            alarm_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            fail_count_q  <= fail_count_d;
            unlock_prev_q <= unlock;
            pwd_prev_q    <= pwd_incorrect;
            entry_en_q    <= entry_en_d;
            door_open_q   <= door_open_d;
            locked_out_q  <= locked_out_d;
            alarm_q       <= alarm_d;
        end
    end

    assign entry_en   = entry_en_q;
    assign door_open  = door_open_q;
    assign locked_out = locked_out_q;
    assign alarm      = alarm_q;
    assign fail_count = fail_count_q;

endmodule
